// File: rtl/i2c_slave_bit_engine.sv
// I2C slave bit engine: synchronizes the raw bus, frames START/STOP, shifts address and
// data bytes, drives ACK/read data on SDA and issues Enable requests to a memory stage.
module i2c_slave_bit_engine #(
    parameter int ADDRESSLENGTH = 8,
    parameter int RESPLAT       = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     SCL,
    input  logic                     SdaIn,
    output logic                     SdaOe,
    output logic                     Enable,
    output logic                     Mode,
    output logic                     RorW,
    output logic [ADDRESSLENGTH-1:0] DirectionBuffer,
    output logic [7:0]               InputBuffer,
    input  logic [7:0]               OutputBuffer,
    input  logic                     AddressFound,
    output logic                     Busy
);

    localparam int LW = $clog2(RESPLAT + 2);
    localparam logic [LW-1:0] LAT_END = LW'(RESPLAT);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_CHK, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_LOAD, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t r_state, r_state_next;

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    logic [3:0]               r_bitcnt, r_bitcnt_next;
    logic [7:0]               r_shift, r_shift_next;
    logic [LW-1:0]            r_lat, r_lat_next;
    logic                     r_sda_oe, r_sda_oe_next;
    logic                     r_enable, r_enable_next;
    logic                     r_mode, r_mode_next;
    logic                     r_rorw, r_rorw_next;
    logic                     r_rw, r_rw_next;
    logic                     r_ack_phase, r_ack_phase_next;
    logic                     r_busy, r_busy_next;
    logic [ADDRESSLENGTH-1:0] r_dirbuf, r_dirbuf_next;
    logic [7:0]               r_inbuf, r_inbuf_next;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            {r_scl_meta, r_scl_sync, r_scl_prev} <= 3'b111;
            {r_sda_meta, r_sda_sync, r_sda_prev} <= 3'b111;
        end else begin
            {r_scl_meta, r_scl_sync, r_scl_prev} <= {SCL, r_scl_meta, r_scl_sync};
            {r_sda_meta, r_sda_sync, r_sda_prev} <= {SdaIn, r_sda_meta, r_sda_sync};
        end
    end

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_lat       <= '0;
            r_sda_oe    <= 1'b0;
            r_enable    <= 1'b0;
            r_mode      <= 1'b0;
            r_rorw      <= 1'b0;
            r_rw        <= 1'b0;
            r_ack_phase <= 1'b0;
            r_busy      <= 1'b0;
            r_dirbuf    <= '0;
            r_inbuf     <= '0;
        end else begin
            r_state     <= r_state_next;
            r_bitcnt    <= r_bitcnt_next;
            r_shift     <= r_shift_next;
            r_lat       <= r_lat_next;
            r_sda_oe    <= r_sda_oe_next;
            r_enable    <= r_enable_next;
            r_mode      <= r_mode_next;
            r_rorw      <= r_rorw_next;
            r_rw        <= r_rw_next;
            r_ack_phase <= r_ack_phase_next;
            r_busy      <= r_busy_next;
            r_dirbuf    <= r_dirbuf_next;
            r_inbuf     <= r_inbuf_next;
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_bitcnt_next    = r_bitcnt;
        r_shift_next     = r_shift;
        r_lat_next       = r_lat;
        r_sda_oe_next    = r_sda_oe;
        r_enable_next    = 1'b0;
        r_mode_next      = r_mode;
        r_rorw_next      = r_rorw;
        r_rw_next        = r_rw;
        r_ack_phase_next = r_ack_phase;
        r_dirbuf_next    = r_dirbuf;
        r_inbuf_next     = r_inbuf;

        if (w_start) begin
            r_state_next  = S_ADDR;
            r_bitcnt_next = '0;
            r_sda_oe_next = 1'b0;
        end else if (w_stop) begin
            r_state_next  = S_IDLE;
            r_sda_oe_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR: begin
                    if (w_scl_rise) begin
                        r_shift_next  = {r_shift[6:0], r_sda_sync};
                        r_bitcnt_next = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_dirbuf_next = {{(ADDRESSLENGTH-7){1'b0}}, r_shift[6:0]};
                            r_rw_next     = r_sda_sync;
                            r_enable_next = 1'b1;
                            r_mode_next   = 1'b0;
                            r_rorw_next   = 1'b0;
                            r_lat_next    = LW'(1);
                            r_state_next  = S_ADDR_CHK;
                        end
                    end
                end
                S_ADDR_CHK: begin
                    if (r_lat == LAT_END) begin
                        r_ack_phase_next = 1'b0;
                        r_sda_oe_next    = 1'b0;
                        r_state_next     = AddressFound ? S_ADDR_ACK : S_WAIT_STOP;
                    end else begin
                        r_lat_next = r_lat + LW'(1);
                    end
                end
                S_ADDR_ACK, S_WR_ACK: begin
                    // First fall drives ACK, second fall releases it and starts the next byte.
                    if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            r_sda_oe_next    = 1'b1;
                            r_ack_phase_next = 1'b1;
                        end else begin
                            r_sda_oe_next = 1'b0;
                            r_bitcnt_next = '0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                r_enable_next = 1'b1;
                                r_mode_next   = 1'b1;
                                r_rorw_next   = 1'b0;
                                r_lat_next    = LW'(1);
                                r_state_next  = S_RD_LOAD;
                            end else begin
                                r_state_next = S_WR_BYTE;
                            end
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (w_scl_rise) begin
                        r_shift_next  = {r_shift[6:0], r_sda_sync};
                        r_bitcnt_next = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            r_inbuf_next     = {r_shift[6:0], r_sda_sync};
                            r_enable_next    = 1'b1;
                            r_mode_next      = 1'b1;
                            r_rorw_next      = 1'b1;
                            r_ack_phase_next = 1'b0;
                            r_state_next     = S_WR_ACK;
                        end
                    end
                end
                S_RD_LOAD: begin
                    if (r_lat == LAT_END) begin
                        r_shift_next  = OutputBuffer;
                        r_sda_oe_next = ~OutputBuffer[7];
                        r_bitcnt_next = '0;
                        r_state_next  = S_RD_BYTE;
                    end else begin
                        r_lat_next = r_lat + LW'(1);
                    end
                end
                S_RD_BYTE: begin
                    if (w_scl_fall) begin
                        if (r_bitcnt == 4'd7) begin
                            r_sda_oe_next    = 1'b0;
                            r_ack_phase_next = 1'b0;
                            r_state_next     = S_RD_ACK;
                        end else begin
                            r_shift_next  = {r_shift[6:0], 1'b0};
                            r_sda_oe_next = ~r_shift[6];
                            r_bitcnt_next = r_bitcnt + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // r_ack_phase remembers a master ACK until the following SCL fall.
                    if (w_scl_rise) begin
                        if (r_sda_sync) begin
                            r_state_next = S_WAIT_STOP;
                        end else begin
                            r_ack_phase_next = 1'b1;
                        end
                    end else if (w_scl_fall && r_ack_phase) begin
                        r_enable_next = 1'b1;
                        r_mode_next   = 1'b1;
                        r_rorw_next   = 1'b0;
                        r_lat_next    = LW'(1);
                        r_state_next  = S_RD_LOAD;
                    end
                end
                S_WAIT_STOP: r_sda_oe_next = 1'b0;
                default: r_state_next = S_IDLE;
            endcase
        end

        r_busy_next = (r_state_next != S_IDLE);
    end

    assign SdaOe           = r_sda_oe;
    assign Enable          = r_enable;
    assign Mode            = r_mode;
    assign RorW            = r_rorw;
    assign DirectionBuffer = r_dirbuf;
    assign InputBuffer     = r_inbuf;
    assign Busy            = r_busy;

endmodule

// File: doc/i2c_slave_bit_engine.md
I2C_SLAVE_BIT_ENGINE -- requirements
Module: i2c_slave_bit_engine

Interface
REQ-001 Parameter ADDRESSLENGTH, 8: width of DirectionBuffer; the 7-bit bus address is zero-extended into it.
REQ-002 Parameter RESPLAT, 2: Clk cycles from Enable pulse to valid AddressFound/OutputBuffer from the memory stage.
REQ-003 Clk  in  1  single system clock; all logic on rising edge.
REQ-004 Reset_n  in  1  synchronous, active-low reset.
REQ-005 SCL  in  1  raw I2C clock, asynchronous to Clk.
REQ-006 SdaIn  in  1  raw I2C data line, asynchronous to Clk.
REQ-007 SdaOe  out  1  1 = pull SDA low (open drain); 0 = release.
REQ-008 Enable  out  1  one-Clk request pulse to the memory stage.
REQ-009 Mode  out  1  0 = address check; 1 = data access.
REQ-010 RorW  out  1  1 = write InputBuffer; 0 = read to OutputBuffer.
REQ-011 DirectionBuffer  out  ADDRESSLENGTH  received address, {0, addr[6:0]}.
REQ-012 InputBuffer  out  8  last received write byte.
REQ-013 OutputBuffer  in  8  byte to transmit on reads.
REQ-014 AddressFound  in  1  memory match flag.
REQ-015 Busy  out  1  1 from START until return to IDLE.

Function
REQ-016 SCL and SdaIn SHALL pass through 2-FF synchronizers; edges are detected on synchronized values (3-cycle input latency).
REQ-017 START = SDA fall while SCL high; STOP = SDA rise while SCL high; detection SHALL override any state.
REQ-018 START (including repeated START) SHALL go to ADDR with the bit counter cleared and SdaOe=0; STOP SHALL go to IDLE with SdaOe=0.
REQ-019 States: IDLE, ADDR, ADDR_CHK, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-020 Data bits SHALL be sampled MSB-first on SCL rising edges; SdaOe SHALL change only on the Clk after an SCL falling edge (RD_LOAD excepted).
REQ-021 ADDR: on the 8th rising edge, latch addr[6:0]/rw bit, update DirectionBuffer, pulse Enable with Mode=0 and enter ADDR_CHK.
REQ-022 ADDR_CHK: sample AddressFound exactly RESPLAT cycles after the pulse; found -> ADDR_ACK; not found -> WAIT_STOP with SdaOe held 0 (NACK).
REQ-023 ADDR_ACK: next SCL fall asserts SdaOe=1 for one SCL period; the following SCL fall goes to WR_BYTE (rw=0) or RD_LOAD (rw=1).
REQ-024 WR_BYTE: on the 8th rising edge, update InputBuffer and pulse Enable with Mode=1, RorW=1; next SCL fall drives ACK (WR_ACK), following fall releases and returns to WR_BYTE.
REQ-025 RD_LOAD: pulse Enable with Mode=1, RorW=0; load OutputBuffer RESPLAT cycles later into the shift register and drive SdaOe=~bit7 immediately; then RD_BYTE.
REQ-026 RD_BYTE: each SCL fall shifts and drives the next bit; the fall after bit 0 releases SdaOe and enters RD_ACK.
REQ-027 RD_ACK: SDA sampled at SCL rise; 0 (ACK) -> RD_LOAD at the next fall; 1 (NACK) -> WAIT_STOP.
REQ-028 Enable SHALL never be high for two consecutive cycles; Mode/RorW SHALL be stable during the Enable pulse and RESPLAT cycles after it.
REQ-029 A START/STOP mid-byte SHALL discard the partial byte without any Enable pulse.

Reset
REQ-030 While Reset_n=0 at a Clk edge: state IDLE; SdaOe, Enable, Mode, RorW, Busy = 0; DirectionBuffer, InputBuffer, bit counter, shift register = 0; synchronizers loaded with 1.
REQ-031 Reset mid-transfer SHALL release SDA on the next edge and ignore the bus until a new START.

Verification
REQ-032 START, address 0x07 write, AddressFound=1 -> DirectionBuffer=0x07, one Enable with Mode=0, SdaOe=1 during the 9th SCL high.
REQ-033 START, address 0x17, AddressFound=0 -> NACK (SdaOe=0 on the 9th clock), following bytes ignored, IDLE after STOP.
REQ-034 Write 0x55 then 0xF5 -> InputBuffer=0x55 then 0xF5, two Enable pulses with Mode=1, RorW=1, both bytes ACKed.
REQ-035 Read with OutputBuffer 0x55 then 0xF5, master ACK then NACK -> SDA serializes 01010101 then 11110101, two Enable pulses with RorW=0, WAIT_STOP.
REQ-036 Repeated START after 4 data bits -> no Enable pulse, new address accepted.
REQ-037 Reset_n low during RD_BYTE with SdaOe=1 -> SdaOe=0 next cycle, Busy=0.
